// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART core.
// Defining UART_PARITY_EN elsewhere enables the parity state that uses these encodings.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned RX_MID     = 7;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Parity bit that makes the frame's total ones count even (odd=0) or odd (odd=1).
  function automatic logic parity_bit(input logic [15:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO with occupancy output; writes when full and
// reads when empty are ignored.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [WIDTH-1:0]           w_data,
  output logic [WIDTH-1:0]           r_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full   = (level == LW'(DEPTH));
  assign empty  = (level == '0);
  assign wr_en  = wr && !full;
  assign rd_en  = rd && !empty;
  assign r_data = mem[rd_ptr];

  // Storage is cleared on reset so the head reads 0 before the first push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= w_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_core_buffered.sv
// Buffered UART: runtime baud divisor, TX/RX FIFOs with levels, sticky error flags.
// Optional parity (port parity_odd plus a PARITY state) when UART_PARITY_EN is defined.
module uart_core_buffered
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned DIV_W   = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DIV_W-1:0]           baud_div,
`ifdef UART_PARITY_EN
  input  logic                       parity_odd,
`endif
  input  logic                       rx,
  output logic                       tx,
  input  logic [DBIT-1:0]            w_data,
  input  logic                       wr_uart,
  output logic                       tx_full,
  output logic [$clog2(DEPTH+1)-1:0] tx_level,
  output logic [DBIT-1:0]            r_data,
  input  logic                       rd_uart,
  output logic                       rx_empty,
  output logic [$clog2(DEPTH+1)-1:0] rx_level,
  output logic                       rx_overrun,
  output logic                       frame_err,
  input  logic                       clr_err
);

  localparam int unsigned SW = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
  localparam int unsigned NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [SW-1:0] S_MID  = SW'(RX_MID);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  // Baud generator: a divisor lowered below the count wraps on the next cycle.
  logic [DIV_W-1:0] baud_cnt;
  logic             tick;

  assign tick = (baud_cnt == baud_div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) baud_cnt <= '0;
    else       baud_cnt <= (baud_cnt >= baud_div) ? '0 : baud_cnt + DIV_W'(1);
  end

  logic            tx_pop;
  logic            tx_empty;
  logic [DBIT-1:0] tx_head;

  uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DBIT)) u_tx_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr_uart),
    .rd     (tx_pop),
    .w_data (w_data),
    .r_data (tx_head),
    .empty  (tx_empty),
    .full   (tx_full),
    .level  (tx_level)
  );

  tx_state_t       tx_state, tx_state_n;
  logic [SW-1:0]   tx_s, tx_s_n;
  logic [NW-1:0]   tx_n, tx_n_n;
  logic [DBIT-1:0] tx_b, tx_b_n;
  logic            tx_bit_n;
  logic            tx_load;
`ifdef UART_PARITY_EN
  logic            tx_p, tx_p_n;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_s     <= '0;
      tx_n     <= '0;
      tx_b     <= '0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_s     <= tx_s_n;
      tx_n     <= tx_n_n;
      tx_b     <= tx_b_n;
      tx       <= tx_bit_n;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_p <= 1'b0;
    else       tx_p <= tx_p_n;
  end
`endif

  // The end of STOP reloads directly so queued bytes go out without an idle gap.
  always_comb begin
    tx_state_n = tx_state;
    tx_s_n     = tx_s;
    tx_n_n     = tx_n;
    tx_b_n     = tx_b;
    tx_load    = 1'b0;
    tx_bit_n   = 1'b1;
`ifdef UART_PARITY_EN
    tx_p_n     = tx_p;
`endif
    if (tick) begin
      case (tx_state)
        TX_IDLE: tx_load = !tx_empty;
        TX_START:
          if (tx_s == S_LAST) begin
            tx_state_n = TX_DATA;
            tx_s_n     = '0;
            tx_n_n     = '0;
          end else tx_s_n = tx_s + SW'(1);
        TX_DATA:
          if (tx_s == S_LAST) begin
            tx_s_n = '0;
            tx_b_n = tx_b >> 1;
            if (tx_n == N_LAST) begin
`ifdef UART_PARITY_EN
              tx_state_n = TX_PARITY;
`else
              tx_state_n = TX_STOP;
`endif
            end else tx_n_n = tx_n + NW'(1);
          end else tx_s_n = tx_s + SW'(1);
`ifdef UART_PARITY_EN
        TX_PARITY:
          if (tx_s == S_LAST) begin
            tx_state_n = TX_STOP;
            tx_s_n     = '0;
          end else tx_s_n = tx_s + SW'(1);
`endif
        TX_STOP:
          if (tx_s == S_STOP) begin
            if (!tx_empty) tx_load    = 1'b1;
            else           tx_state_n = TX_IDLE;
          end else tx_s_n = tx_s + SW'(1);
        default: tx_state_n = TX_IDLE;
      endcase
    end
    if (tx_load) begin
      tx_state_n = TX_START;
      tx_s_n     = '0;
      tx_b_n     = tx_head;
`ifdef UART_PARITY_EN
      tx_p_n     = parity_bit(16'(tx_head), parity_odd);
`endif
    end
    case (tx_state_n)
      TX_START: tx_bit_n = 1'b0;
      TX_DATA:  tx_bit_n = tx_b_n[0];
`ifdef UART_PARITY_EN
      TX_PARITY: tx_bit_n = tx_p_n;
`endif
      default:  tx_bit_n = 1'b1;
    endcase
  end

  assign tx_pop = tx_load;

  logic rx_s1, rx_s2, rx_s3;
  logic rx_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall = rx_s3 & ~rx_s2;

  rx_state_t       rx_state, rx_state_n;
  logic [SW-1:0]   rx_s, rx_s_n;
  logic [NW-1:0]   rx_n, rx_n_n;
  logic [DBIT-1:0] rx_b, rx_b_n;
  logic            rx_push;
  logic            ferr_set;
  logic            rx_full;
  logic            rx_bad;
`ifdef UART_PARITY_EN
  logic            rx_perr, rx_perr_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_perr <= 1'b0;
    else       rx_perr <= rx_perr_n;
  end

  assign rx_bad = !rx_s2 || rx_perr;
`else
  assign rx_bad = !rx_s2;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_s     <= '0;
      rx_n     <= '0;
      rx_b     <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_s     <= rx_s_n;
      rx_n     <= rx_n_n;
      rx_b     <= rx_b_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_s_n     = rx_s;
    rx_n_n     = rx_n;
    rx_b_n     = rx_b;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
`ifdef UART_PARITY_EN
    rx_perr_n  = rx_perr;
`endif
    case (rx_state)
      RX_IDLE:
        if (rx_fall) begin
          rx_state_n = RX_START;
          rx_s_n     = '0;
        end
      RX_START:
        if (tick) begin
          if (rx_s == S_MID) begin
            if (rx_s2) rx_state_n = RX_IDLE;
            else begin
              rx_state_n = RX_DATA;
              rx_s_n     = '0;
              rx_n_n     = '0;
            end
          end else rx_s_n = rx_s + SW'(1);
        end
      RX_DATA:
        if (tick) begin
          if (rx_s == S_LAST) begin
            rx_s_n = '0;
            rx_b_n = {rx_s2, rx_b[DBIT-1:1]};
            if (rx_n == N_LAST) begin
`ifdef UART_PARITY_EN
              rx_state_n = RX_PARITY;
`else
              rx_state_n = RX_STOP;
`endif
            end else rx_n_n = rx_n + NW'(1);
          end else rx_s_n = rx_s + SW'(1);
        end
`ifdef UART_PARITY_EN
      RX_PARITY:
        if (tick) begin
          if (rx_s == S_LAST) begin
            rx_s_n     = '0;
            rx_perr_n  = (rx_s2 != parity_bit(16'(rx_b), parity_odd));
            rx_state_n = RX_STOP;
          end else rx_s_n = rx_s + SW'(1);
        end
`endif
      RX_STOP:
        if (tick) begin
          if (rx_s == S_STOP) begin
            rx_state_n = RX_IDLE;
            if (rx_bad) ferr_set = 1'b1;
            else        rx_push  = 1'b1;
          end else rx_s_n = rx_s + SW'(1);
        end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DBIT)) u_rx_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (rx_push),
    .rd     (rd_uart),
    .w_data (rx_b),
    .r_data (r_data),
    .empty  (rx_empty),
    .full   (rx_full),
    .level  (rx_level)
  );

  // A set in the same cycle as clr_err takes priority over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (rx_push && rx_full) rx_overrun <= 1'b1;
      else if (clr_err)       rx_overrun <= 1'b0;
      if (ferr_set)           frame_err  <= 1'b1;
      else if (clr_err)       frame_err  <= 1'b0;
    end
  end

endmodule
